// File: rtl/psum_pkg.sv
// psum_tx_seq shared definitions: info field layout and sequencer states.
// Used by the tx sequencer and its bench via import psum_pkg::*.
package psum_pkg;

  localparam int PSUM_ADDR_LSB = 0;
  localparam int PSUM_ADDR_MSB = 11;
  localparam int PSUM_ACC_BIT  = 12;
  localparam int PSUM_ID_BIT   = 13;
  localparam int PSUM_TAG_LSB  = 14;
  localparam int PSUM_TAG_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DONE  = 2'd3
  } psum_state_e;

endpackage

// File: rtl/sirv_gnrl_pipe_stage.sv
// Generic one-entry valid/ready pipe register (DP=0 is a wire).
// CUT_READY=1 breaks the ready path at the cost of a bubble.
module sirv_gnrl_pipe_stage #(
  parameter int CUT_READY = 0,
  parameter int DP        = 1,
  parameter int DW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  generate
    if (DP == 0) begin : g_pass
      assign o_vld = i_vld;
      assign i_rdy = o_rdy;
      assign o_dat = i_dat;
    end else begin : g_reg
      logic          vld_q;
      logic [DW-1:0] dat_q;
      logic          vld_set;
      logic          vld_clr;

      assign vld_set = i_vld & i_rdy;
      assign vld_clr = vld_q & o_rdy;

      // valid flag: set on load, clear on drain without reload
      always_ff @(posedge clk) begin
        if (!rst_n)
          vld_q <= 1'b0;
        else if (vld_set | vld_clr)
          vld_q <= vld_set | ~vld_clr;
      end

      // payload captured only on load, so it holds under backpressure
      always_ff @(posedge clk) begin
        if (!rst_n)
          dat_q <= '0;
        else if (vld_set)
          dat_q <= i_dat;
      end

      if (CUT_READY == 1) begin : g_cut
        assign i_rdy = ~vld_q;
      end else begin : g_nocut
        assign i_rdy = ~vld_q | vld_clr;
      end

      assign o_vld = vld_q;
      assign o_dat = dat_q;
    end
  endgenerate

endmodule

// File: rtl/psum_tx_seq.sv
// Two-pass psum tx sequencer: tags MAC beats with buffer addr/pass info.
// Optional PSUM_TX_TILE_TAG_EN adds an 8-bit tile tag on info[21:14].
module psum_tx_seq
  import psum_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DW     = 64,
  parameter int IW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [ADDR_W:0] cfg_len,
  input  logic          cfg_identity_en,
  output logic          busy,
  output logic          done,
  input  logic          mac_vld,
  output logic          mac_rdy,
  input  logic [DW-1:0] mac_data,
  output logic [IW-1:0] mac_array2psum_acc_info,
  output logic [DW-1:0] mac_array2psum_acc_data,
  output logic          mac_array2psum_acc_vld,
  input  logic          mac_array2psum_acc_rdy
);

  localparam logic [ADDR_W:0] ONE = 1;

  psum_state_e     state;
  psum_state_e     state_nxt;
  logic [ADDR_W:0] addr;
  logic [ADDR_W:0] len_q;
  logic            id_en_q;
  logic            active;
  logic            pass1;
  logic            in_hs;
  logic            last;
  logic            pipe_rdy;
  logic [IW-1:0]   info_in;

  assign active  = (state == ST_PASS0) | (state == ST_PASS1);
  assign pass1   = (state == ST_PASS1);
  assign mac_rdy = active & pipe_rdy;
  assign in_hs   = mac_vld & mac_rdy;
  assign last    = (addr == len_q - ONE);
  assign busy    = (state != ST_IDLE);

  // next state; done fires once the out register has drained
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:
        if (cfg_start)
          state_nxt = (cfg_len == '0) ? ST_DONE : ST_PASS0;
      ST_PASS0:
        if (in_hs && last) state_nxt = ST_PASS1;
      ST_PASS1:
        if (in_hs && last) state_nxt = ST_DONE;
      ST_DONE:
        if (!mac_array2psum_acc_vld) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // tile config capture and per-beat buffer address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr    <= '0;
      len_q   <= '0;
      id_en_q <= 1'b0;
    end else if ((state == ST_IDLE) && cfg_start) begin
      addr    <= '0;
      len_q   <= cfg_len;
      id_en_q <= cfg_identity_en;
    end else if (in_hs) begin
      addr <= last ? '0 : addr + ONE;
    end
  end

`ifdef PSUM_TX_TILE_TAG_EN
  logic [PSUM_TAG_W-1:0] tag_q;

  // tile tag advances on every completed tile, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n)    tag_q <= '0;
    else if (done) tag_q <= tag_q + 1'b1;
  end
`endif

  // info word for the beat being accepted this cycle
  always_comb begin
    info_in = '0;
    info_in[PSUM_ADDR_LSB +: ADDR_W] = addr[ADDR_W-1:0];
    info_in[PSUM_ACC_BIT] = pass1;
    info_in[PSUM_ID_BIT]  = pass1 & id_en_q;
`ifdef PSUM_TX_TILE_TAG_EN
    info_in[PSUM_TAG_LSB +: PSUM_TAG_W] = tag_q;
`endif
  end

  sirv_gnrl_pipe_stage #(
    .CUT_READY (0),
    .DP        (1),
    .DW        (IW + DW)
  ) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (mac_vld & active),
    .i_rdy (pipe_rdy),
    .i_dat ({info_in, mac_data}),
    .o_vld (mac_array2psum_acc_vld),
    .o_rdy (mac_array2psum_acc_rdy),
    .o_dat ({mac_array2psum_acc_info, mac_array2psum_acc_data})
  );

endmodule

// File: tb/tb_psum_tx_seq.sv
// Bench for psum_tx_seq: queue model of expected beats per tile,
// per-cycle compare process and literal pins on the observed info words.
module tb_psum_tx_seq;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic          cfg_identity_en = 1'b0;
  logic          busy;
  logic          done;
  logic          mac_vld;
  logic          mac_rdy;
  logic [DW-1:0] mac_data;
  logic [IW-1:0] o_info;
  logic [DW-1:0] o_data;
  logic          o_vld;
  logic          o_rdy = 1'b1;

  always #5 clk = ~clk;

  psum_tx_seq #(.ADDR_W(AW), .DW(DW), .IW(IW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cfg_start               (cfg_start),
    .cfg_len                 (cfg_len),
    .cfg_identity_en         (cfg_identity_en),
    .busy                    (busy),
    .done                    (done),
    .mac_vld                 (mac_vld),
    .mac_rdy                 (mac_rdy),
    .mac_data                (mac_data),
    .mac_array2psum_acc_info (o_info),
    .mac_array2psum_acc_data (o_data),
    .mac_array2psum_acc_vld  (o_vld),
    .mac_array2psum_acc_rdy  (o_rdy)
  );

  typedef struct {
    logic [31:0] info;
    logic [63:0] data;
  } beat_t;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int tag_model = 0;
  beat_t exp_q[$];
  logic [31:0] obs_info[$];
  int hs_cyc[$];

  int src_idx = 0;
  int src_n = 0;
  logic [63:0] src_base = '0;

  assign mac_vld  = (src_idx < src_n);
  assign mac_data = src_base + 64'(src_idx);

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // MAC source: advance to the next beat after each input handshake
  always begin
    bit hs;
    @(negedge clk);
    hs = mac_vld && mac_rdy && rst_n;
    @(posedge clk);
    #1;
    if (hs) src_idx++;
  end

  // compare process: every output handshake against the model queue
  logic        pstall = 1'b0;
  logic [31:0] pinfo = '0;
  logic [63:0] pdata = '0;
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        chk("hold_vld", 64'(o_vld), 64'd1);
        chk("hold_info", 64'(o_info), 64'(pinfo));
        chk("hold_data", o_data, pdata);
      end
      if (o_vld && !o_rdy)
        chk("mac_rdy_full", 64'(mac_rdy), 64'd0);
      if (o_vld && o_rdy) begin
        obs_info.push_back(o_info);
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_info", 64'(o_info), 64'(b.info));
          chk("beat_data", o_data, b.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pstall = o_vld && !o_rdy;
      pinfo  = o_info;
      pdata  = o_data;
    end
  end

  task automatic start_tile(int len, bit id, logic [63:0] base);
    beat_t b;
    obs_info.delete();
    hs_cyc.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < len; i++) begin
        b.info = 32'(i) | (32'(p) << 12) | (32'(id && p == 1) << 13);
`ifdef PSUM_TX_TILE_TAG_EN
        b.info = b.info | (32'(tag_model & 255) << 14);
`endif
        b.data = base + 64'(p * len + i);
        exp_q.push_back(b);
      end
    @(posedge clk);
    #1;
    src_base = base;
    src_idx = 0;
    src_n = 2 * len;
    cfg_start = 1'b1;
    cfg_len = (AW+1)'(len);
    cfg_identity_en = id;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(string name, int bound);
    int c0 = done_cnt;
    int k = 0;
    while (done_cnt == c0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_timeout"}, 64'(done_cnt != c0), 64'd1);
    @(negedge clk);
    chk({name, "_done_1cyc"}, 64'(done), 64'd0);
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    tag_model++;
  endtask

  task automatic wait_hs(int n, int bound);
    int k = 0;
    while (hs_cyc.size() < n && k < bound) begin
      @(posedge clk);
      k++;
    end
    chk("wait_hs_timeout", 64'(hs_cyc.size() >= n), 64'd1);
  endtask

  initial begin
    int bcnt;
    int vcnt;
    int dcnt;
    int c0;
    int k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mac_rdy", 64'(mac_rdy), 64'd0);
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_info", 64'(o_info), 64'd0);
    chk("rst_data", o_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic two-pass tile, no backpressure
    start_tile(4, 1'b0, 64'h10);
    wait_done("t1", 100);
    chk("t1_beats", 64'(obs_info.size()), 64'd8);
    if (obs_info.size() == 8) begin
      chk("t1_info0", 64'(obs_info[0] & 32'h3fff), 64'h0);
      chk("t1_info3", 64'(obs_info[3] & 32'h3fff), 64'h3);
      chk("t1_info4", 64'(obs_info[4] & 32'h3fff), 64'h1000);
      chk("t1_info7", 64'(obs_info[7] & 32'h3fff), 64'h1003);
      chk("t1_nobubble", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);
      chk("t1_done_time", 64'(done_cyc), 64'(hs_cyc[7] + 1));
    end

    // identity select on pass 1
    start_tile(3, 1'b1, 64'h20);
    wait_done("t2", 100);
    chk("t2_beats", 64'(obs_info.size()), 64'd6);
    if (obs_info.size() == 6) begin
      chk("t2_p0_id", 64'(obs_info[2][13]), 64'd0);
      chk("t2_info3", 64'(obs_info[3] & 32'h3fff), 64'h3000);
      chk("t2_info4", 64'(obs_info[4] & 32'h3fff), 64'h3001);
      chk("t2_info5", 64'(obs_info[5] & 32'h3fff), 64'h3002);
    end

    // output backpressure in the middle of pass 1
    start_tile(6, 1'b0, 64'h100);
    wait_hs(7, 100);
    @(posedge clk);
    #1;
    o_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    o_rdy = 1'b1;
    wait_done("t3", 100);
    chk("t3_beats", 64'(obs_info.size()), 64'd12);

    // zero-length tile
    obs_info.delete();
    @(posedge clk);
    #1;
    src_n = 0;
    cfg_start = 1'b1;
    cfg_len = '0;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    bcnt = 0;
    vcnt = 0;
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      bcnt += int'(busy);
      vcnt += int'(o_vld);
      dcnt += int'(done);
    end
    chk("t4_busy_cycles", 64'(bcnt), 64'd1);
    chk("t4_done_pulses", 64'(dcnt), 64'd1);
    chk("t4_no_vld", 64'(vcnt), 64'd0);
    tag_model++;

    // full 4096-entry tile with a stray start mid tile
    start_tile(4096, 1'b0, 64'h10000);
    wait_hs(100, 400);
    @(posedge clk);
    #1;
    cfg_start = 1'b1;
    cfg_len = 13'd1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    wait_done("t5", 9000);
    chk("t5_beats", 64'(obs_info.size()), 64'd8192);
    if (obs_info.size() == 8192) begin
      chk("t5_info4095", 64'(obs_info[4095] & 32'h3fff), 64'hfff);
      chk("t5_info4096", 64'(obs_info[4096] & 32'h3fff), 64'h1000);
    end

    // reset mid pass 0 while a beat is held
    start_tile(8, 1'b0, 64'h200);
    o_rdy = 1'b0;
    k = 0;
    while (!o_vld && k < 50) begin
      @(posedge clk);
      k++;
    end
    chk("t6_vld_seen", 64'(o_vld), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o_rdy = 1'b1;
    src_n = 0;
    exp_q.delete();
    tag_model = 0;
    c0 = done_cnt;
    @(negedge clk);
    chk("t6_vld_after_rst", 64'(o_vld), 64'd0);
    chk("t6_busy_after_rst", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("t6_no_done", 64'(done_cnt), 64'(c0));

    start_tile(2, 1'b0, 64'h300);
    wait_done("t7", 100);
    chk("t7_beats", 64'(obs_info.size()), 64'd4);
    if (obs_info.size() == 4) begin
      chk("t7_info0", 64'(obs_info[0]), 64'h0);
      chk("t7_info1", 64'(obs_info[1]), 64'h1);
    end

    start_tile(1, 1'b0, 64'h400);
    wait_done("t8", 100);
    chk("t8_beats", 64'(obs_info.size()), 64'd2);
    if (obs_info.size() == 2) begin
`ifdef PSUM_TX_TILE_TAG_EN
      chk("t8_tag1", 64'(obs_info[0]), 64'h4000);
`else
      chk("t8_notag", 64'(obs_info[0]), 64'h0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
